// File: rtl/still_frame_buffer_if.sv
// Capture-stream, status and read-port signals of still_frame_buffer.
// The design side uses the slave modport; the driving logic uses master.
interface still_frame_buffer_if #(
  parameter int PIX_W = 8
);
  logic             arm;
  logic             write;
  logic [7:0]       x;
  logic [7:0]       y;
  logic [PIX_W-1:0] pixel;
  logic             busy;
  logic             frame_done;
  logic             rd_req;
  logic [7:0]       rd_x;
  logic [7:0]       rd_y;
  logic             rd_valid;
  logic [PIX_W-1:0] rd_data;

  modport master (
    output arm, write, x, y, pixel, rd_req, rd_x, rd_y,
    input  busy, frame_done, rd_valid, rd_data
  );

  modport slave (
    input  arm, write, x, y, pixel, rd_req, rd_x, rd_y,
    output busy, frame_done, rd_valid, rd_data
  );
endinterface

// File: rtl/still_frame_buffer.sv
// Single-frame still buffer: stores one WIDTH x HEIGHT frame from the capture
// stream and serves (x,y) reads once held. STILL_DROP_COUNT_EN adds drop_count.
module still_frame_buffer #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int PIX_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  still_frame_buffer_if.slave  bus
`ifdef STILL_DROP_COUNT_EN
  ,
  output logic [15:0]          drop_count
`endif
);

  localparam int         DEPTH  = WIDTH * HEIGHT;
  localparam int         AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] W_LIM  = 9'(WIDTH);
  localparam logic [8:0] H_LIM  = 9'(HEIGHT);
  localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
  localparam logic [7:0] Y_LAST = 8'(HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_READY
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             capturing;
  logic             wr_in_range;
  logic             wr_en;
  logic             done_now;
  logic             rd_in_range;
  logic             rd_accept;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;
  logic [PIX_W-1:0] mem [DEPTH];

  always_comb begin
    capturing   = (state == S_CAPTURE);
    wr_in_range = ({1'b0, bus.x} < W_LIM) && ({1'b0, bus.y} < H_LIM);
    rd_in_range = ({1'b0, bus.rd_x} < W_LIM) && ({1'b0, bus.rd_y} < H_LIM);
    wr_addr     = AW'(16'(bus.y) * 16'(WIDTH) + 16'(bus.x));
    rd_addr     = AW'(16'(bus.rd_y) * 16'(WIDTH) + 16'(bus.rd_x));
    wr_en       = capturing && bus.write && wr_in_range;
    rd_accept   = bus.rd_req && !capturing;
    // A coincident arm restarts capture, so the final pixel is kept but no completion
    done_now    = wr_en && (bus.x == X_LAST) && (bus.y == Y_LAST) && !bus.arm;
  end

  always_comb begin
    state_next = state;
    bus.busy   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.arm) state_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        bus.busy = 1'b1;
        if (bus.arm)       state_next = S_CAPTURE;
        else if (done_now) state_next = S_READY;
      end
      S_READY: begin
        if (bus.arm) state_next = S_CAPTURE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      bus.frame_done <= 1'b0;
      bus.rd_valid   <= 1'b0;
      bus.rd_data    <= '0;
    end else begin
      state          <= state_next;
      bus.frame_done <= done_now;
      bus.rd_valid   <= rd_accept;
      if (rd_accept) bus.rd_data <= rd_in_range ? mem[rd_addr] : '0;
    end
  end

  // Frame storage is deliberately not reset so a partial frame survives reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= bus.pixel;
  end

`ifdef STILL_DROP_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_count <= '0;
    end else if (bus.arm) begin
      drop_count <= '0;
    end else if (capturing && bus.write && !wr_in_range && (drop_count != '1)) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_still_frame_buffer.sv
// Randomized self-checking bench for still_frame_buffer (WIDTH=4, HEIGHT=3)
// against a frame-array model; honours STILL_DROP_COUNT_EN when defined.
module tb_still_frame_buffer;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int PW = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  still_frame_buffer_if #(.PIX_W(PW)) bus ();
`ifdef STILL_DROP_COUNT_EN
  logic [15:0] drop_count;
`endif

  still_frame_buffer #(.WIDTH(W), .HEIGHT(H), .PIX_W(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef STILL_DROP_COUNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: frame contents plus "capture in progress" flag
  logic [7:0] ref_mem [W*H];
  bit         m_cap;
  bit         exp_done;
  bit         exp_valid;
  logic [7:0] exp_data;
  int         exp_drop;

  task automatic step(input bit a, input bit w, input logic [7:0] xx, input logic [7:0] yy,
                      input logic [7:0] pp, input bit rq, input logic [7:0] rx,
                      input logic [7:0] ry);
    bit in_w, in_r;
    bus.arm = a; bus.write = w; bus.x = xx; bus.y = yy; bus.pixel = pp;
    bus.rd_req = rq; bus.rd_x = rx; bus.rd_y = ry;
    in_r = (rx < W) && (ry < H);
    in_w = (xx < W) && (yy < H);
    exp_valid = rq && !m_cap;
    if (exp_valid) exp_data = in_r ? ref_mem[int'(ry) * W + int'(rx)] : 8'h00;
    exp_done = m_cap && w && in_w && (xx == W - 1) && (yy == H - 1) && !a;
    if (m_cap && w && in_w) ref_mem[int'(yy) * W + int'(xx)] = pp;
    if (a) exp_drop = 0;
    else if (m_cap && w && !in_w && exp_drop < 65535) exp_drop++;
    if (a) m_cap = 1'b1;
    else if (exp_done) m_cap = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic model_reset();
    m_cap = 1'b0; exp_done = 1'b0; exp_valid = 1'b0; exp_drop = 0;
  endtask

  task automatic test_reset();
    bus.arm = 0; bus.write = 0; bus.x = 0; bus.y = 0; bus.pixel = 0;
    bus.rd_req = 0; bus.rd_x = 0; bus.rd_y = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.frame_done); end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.rd_valid); end
    checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bus.rd_data); end
`ifdef STILL_DROP_COUNT_EN
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
`endif
    reset = 1'b1;
    idle();
  endtask

  task automatic test_capture();
    step(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL cap_busy_arm: got %b want 1", bus.busy); end
    for (int yy = 0; yy < H; yy++) begin
      for (int xx = 0; xx < W; xx++) begin
        step(1'b0, 1'b1, 8'(xx), 8'(yy), 8'(yy * 4 + xx), 1'b0, 8'd0, 8'd0);
        checks++; if (bus.frame_done !== exp_done) begin errors++; $display("FAIL cap_done(%0d,%0d): got %b want %b", xx, yy, bus.frame_done, exp_done); end
        checks++; if (bus.busy !== m_cap) begin errors++; $display("FAIL cap_busy(%0d,%0d): got %b want %b", xx, yy, bus.busy, m_cap); end
      end
    end
    idle();
    checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL cap_done_pulse: got %b want 0", bus.frame_done); end
    step(1'b0, 1'b1, 8'd3, 8'd2, 8'hEE, 1'b0, 8'd0, 8'd0);
    checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL ready_write_done: got %b want 0", bus.frame_done); end
  endtask

  task automatic test_readback();
    for (int i = 0; i < W * H + 6; i++) begin
      logic [7:0] rx, ry;
      if (i < W * H) begin rx = 8'(i % W); ry = 8'(i / W); end
      else begin rx = 8'($urandom_range(0, 7)); ry = 8'($urandom_range(0, 4)); end
      step(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b1, rx, ry);
      checks++; if (bus.rd_valid !== exp_valid) begin errors++; $display("FAIL rd_valid(%0d,%0d): got %b want %b", rx, ry, bus.rd_valid, exp_valid); end
      checks++; if (bus.rd_data !== exp_data) begin errors++; $display("FAIL rd_data(%0d,%0d): got %h want %h", rx, ry, bus.rd_data, exp_data); end
    end
    idle();
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_pulse: got %b want 0", bus.rd_valid); end
  endtask

  task automatic test_oob_write();
    step(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0);
    for (int i = 0; i < W * H - 1; i++)
      step(1'b0, 1'b1, 8'(i % W), 8'(i / W), 8'($urandom), 1'b0, 8'd0, 8'd0);
    step(1'b0, 1'b1, 8'd5, 8'd1, 8'hAA, 1'b0, 8'd0, 8'd0);
    checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL oob_done: got %b want 0", bus.frame_done); end
`ifdef STILL_DROP_COUNT_EN
    checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL oob_drop1: got %0d want 1", drop_count); end
`endif
    for (int i = 0; i < 6; i++) begin
      logic [7:0] xx, yy;
      if ($urandom_range(0, 1) == 0) begin xx = 8'($urandom_range(W, 255)); yy = 8'($urandom_range(0, 255)); end
      else begin xx = 8'($urandom_range(0, 255)); yy = 8'($urandom_range(H, 255)); end
      step(1'b0, 1'b1, xx, yy, 8'($urandom), 1'b0, 8'd0, 8'd0);
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL oob_busy(%0d,%0d): got %b want 1", xx, yy, bus.busy); end
    end
`ifdef STILL_DROP_COUNT_EN
    checks++; if (drop_count !== 16'(exp_drop)) begin errors++; $display("FAIL oob_drop: got %0d want %0d", drop_count, exp_drop); end
`endif
    step(1'b0, 1'b1, 8'd3, 8'd2, 8'($urandom), 1'b0, 8'd0, 8'd0);
    checks++; if (bus.frame_done !== 1'b1) begin errors++; $display("FAIL oob_final_done: got %b want 1", bus.frame_done); end
  endtask

  task automatic test_read_capture();
    step(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0);
`ifdef STILL_DROP_COUNT_EN
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL arm_clears_drop: got %0d want 0", drop_count); end
`endif
    step(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 8'd1, 8'd1);
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL cap_read_valid: got %b want 0", bus.rd_valid); end
    for (int i = 0; i < W * H; i++)
      step(1'b0, 1'b1, 8'(i % W), 8'(i / W), 8'($urandom), 1'b1, 8'(i % W), 8'd0);
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL cap_read_last: got %b want 0", bus.rd_valid); end
    step(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 8'd7, 8'd0);
    checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL oor_read_valid: got %b want 1", bus.rd_valid); end
    checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL oor_read_data: got %h want 00", bus.rd_data); end
  endtask

  task automatic test_arm_final();
    logic [7:0] old;
    step(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0);
    for (int i = 0; i < W * H - 1; i++)
      step(1'b0, 1'b1, 8'(i % W), 8'(i / W), 8'($urandom), 1'b0, 8'd0, 8'd0);
    step(1'b1, 1'b1, 8'd3, 8'd2, 8'($urandom), 1'b0, 8'd0, 8'd0);
    checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL arm_final_done: got %b want 0", bus.frame_done); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL arm_final_busy: got %b want 1", bus.busy); end
    idle();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL arm_final_busy2: got %b want 1", bus.busy); end
    for (int i = 0; i < W * H; i++)
      step(1'b0, 1'b1, 8'(i % W), 8'(i / W), 8'($urandom), 1'b0, 8'd0, 8'd0);
    checks++; if (bus.frame_done !== 1'b1) begin errors++; $display("FAIL arm_final_redone: got %b want 1", bus.frame_done); end
    // Read coincident with arm in S_READY returns the held frame
    old = ref_mem[1 * W + 2];
    step(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 8'd2, 8'd1);
    checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL arm_read_valid: got %b want 1", bus.rd_valid); end
    checks++; if (bus.rd_data !== old) begin errors++; $display("FAIL arm_read_data: got %h want %h", bus.rd_data, old); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL arm_read_busy: got %b want 1", bus.busy); end
    for (int i = 0; i < W * H; i++)
      step(1'b0, 1'b1, 8'(i % W), 8'(i / W), 8'($urandom), 1'b0, 8'd0, 8'd0);
  endtask

  task automatic test_rearm();
    step(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0);
    step(1'b0, 1'b1, 8'd0, 8'd0, 8'h55, 1'b0, 8'd0, 8'd0);
    for (int i = 1; i < W * H; i++)
      step(1'b0, 1'b1, 8'(i % W), 8'(i / W), 8'($urandom), 1'b0, 8'd0, 8'd0);
    checks++; if (bus.frame_done !== 1'b1) begin errors++; $display("FAIL rearm_done: got %b want 1", bus.frame_done); end
    step(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 8'd0, 8'd0);
    checks++; if (bus.rd_data !== 8'h55 || bus.rd_valid !== 1'b1) begin errors++; $display("FAIL rearm_read00: got %h/%b want 55/1", bus.rd_data, bus.rd_valid); end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0);
    for (int i = 0; i < W * H; i++)
      step(1'b0, 1'b1, 8'(i % W), 8'(i / W), 8'($urandom), 1'b0, 8'd0, 8'd0);
    #2 reset = 1'b0; model_reset();
    #1;
    checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", bus.frame_done); end
    #1 reset = 1'b1;
    step(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 8'd1, 8'd2);
    checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %b want 1", bus.rd_valid); end
    #2 reset = 1'b0; model_reset();
    #1;
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus.rd_valid); end
    checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", bus.rd_data); end
    #1 reset = 1'b1;
    step(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0);
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, 8'(i % W), 8'(i / W), 8'($urandom), 1'b0, 8'd0, 8'd0);
    #2 reset = 1'b0; model_reset();
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    #1 reset = 1'b1;
    idle();
  endtask

  initial begin
    test_reset();
    test_capture();
    test_readback();
    test_oob_write();
    test_readback();
    test_read_capture();
    test_readback();
    test_arm_final();
    test_readback();
    test_rearm();
    test_readback();
    test_reset_mid();
    test_readback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
